xosera_bus_host: RTL and testbench

- Bus initiator for the Xosera 8-bit m68k-style register bus; the host-side counterpart of the Xosera bus target.
- Converts 16-bit register read/write requests into one or two byte bus cycles: even/high byte (bytesel=0), then odd/low byte (bytesel=1).
- Enforces programmable setup, strobe and hold timing.
- Used by on-FPGA host logic and by benches that drive Xosera over its pins.

---
 rtl/xosera_bus_host_pkg.sv | 47 ++++
 rtl/xosera_bus_host_sync2.sv | 36 +++
 rtl/xosera_bus_host.sv | 213 +++++++++++++++++++++
 tb/tb_xosera_bus_host.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_bus_host_pkg.sv
// -----------------------------------------------------------------------------
// xv : shared Xosera bus definitions
//
// Purpose
//   Constants and types shared by the Xosera bus host and its helpers:
//   bus polarity constants, the host FSM state type, the latched request
//   record and a small elaboration-time helper.
//
// Contents
//   CS_ENABLED / CS_DISABLED  chip-select pin levels
//   RnW_READ / RnW_WRITE      rd_nwr pin levels
//   host_state_t              IDLE / SETUP / STROBE / HOLD
//   host_req_t                request fields held for a whole transaction
//   max3()                    largest of three phase lengths
// -----------------------------------------------------------------------------
package xv;

    localparam logic CS_ENABLED  = 1'b0;
    localparam logic CS_DISABLED = 1'b1;
    localparam logic RnW_READ    = 1'b1;
    localparam logic RnW_WRITE   = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } host_state_t;

    // 'byte' is a keyword, so the single-byte flag is called byte_mode
    typedef struct packed {
        logic        write;
        logic        byte_mode;
        logic        bytesel;
        logic [3:0]  reg_num;
        logic [15:0] wdata;
    } host_req_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/xosera_bus_host_sync2.sv
// -----------------------------------------------------------------------------
// xosera_sync2 : two-flop synchronizer with asynchronous active-low reset
//
// Purpose
//   Brings a single asynchronous level into the clk domain. Both flops
//   reset to RESET_VAL so an inactive level is presented during reset.
//
// Ports
//   clk      in   destination clock
//   reset_n  in   asynchronous active-low reset
//   d        in   asynchronous input level
//   q        out  synchronized level, two clocks of latency
// -----------------------------------------------------------------------------
module xosera_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full clock to settle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xosera_bus_host.sv
// -----------------------------------------------------------------------------
// xosera_bus_host : bus initiator for the Xosera 8-bit register bus
//
// Purpose
//   Turns 16-bit register read/write requests into one (byte mode) or two
//   (word mode) byte cycles on the Xosera pins. Word transfers go even/high
//   byte first (bytesel=0), then odd/low byte (bytesel=1). Every byte cycle
//   is SETUP_CYCLES clocks of stable fields with cs_n high, STROBE_CYCLES
//   clocks with cs_n low, then HOLD_CYCLES clocks with cs_n high.
//
// Parameters
//   SETUP_CYCLES   clocks of setup before strobe (>=1)
//   STROBE_CYCLES  clocks cs_n is held low     (>=1)
//   HOLD_CYCLES    clocks of hold after strobe  (>=1)
//
// Ports
//   clk, reset_n_i             clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//   req_write_i, req_byte_i, req_bytesel_i, req_reg_num_i, req_wdata_i
//                              request fields
//   rsp_valid_o                one-clock completion pulse
//   rsp_rdata_o                last read data, held until the next read ends
//   bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o,
//   bus_data_o, bus_data_oe_o, bus_data_i
//                              Xosera pin interface
//   bus_irq_n_i / irq_o        target interrupt in, pending interrupt out
//
// Configuration
//   XOSERA_BUS_HOST_IRQ_SYNC_EN  when defined, bus_irq_n_i is passed through
//                                a two-flop synchronizer; otherwise irq_o is
//                                a combinational inversion of bus_irq_n_i.
// -----------------------------------------------------------------------------
module xosera_bus_host
    import xv::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset_n_i,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_byte_i,
    input  logic        req_bytesel_i,
    input  logic [3:0]  req_reg_num_i,
    input  logic [15:0] req_wdata_i,

    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,

    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic        bus_bytesel_o,
    output logic [3:0]  bus_reg_num_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i,

    input  logic        bus_irq_n_i,
    output logic        irq_o
);

    localparam int MAX_CYCLES = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    host_state_t      state,      state_next;
    logic [CNT_W-1:0] cnt,        cnt_next;
    logic             byte_idx,   byte_idx_next;
    host_req_t        req,        req_next;
    logic [15:0]      rbuf,       rbuf_next;
    logic             rsp_valid,  rsp_valid_next;
    logic [15:0]      rsp_rdata,  rsp_rdata_next;

    // State register. Reset drops any transaction in flight; because every
    // pin output is derived from these flops, the pins return to their idle
    // levels as soon as reset_n_i falls.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_idx  <= 1'b0;
            req       <= '0;
            rbuf      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            byte_idx  <= byte_idx_next;
            req       <= req_next;
            rbuf      <= rbuf_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
        end
    end

    // Next-state logic. One shared down-counter times every phase: it is
    // loaded with (phase length - 1) when a phase is entered and the phase
    // ends on the clock where it reads zero.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        byte_idx_next  = byte_idx;
        req_next       = req;
        rbuf_next      = rbuf;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata;

        unique case (state)
            IDLE: begin
                if (req_valid_i) begin
                    req_next.write     = req_write_i;
                    req_next.byte_mode = req_byte_i;
                    req_next.bytesel   = req_bytesel_i;
                    req_next.reg_num   = req_reg_num_i;
                    req_next.wdata     = req_wdata_i;
                    byte_idx_next      = 1'b0;
                    cnt_next           = SETUP_LOAD;
                    state_next         = SETUP;
                end
            end

            SETUP: begin
                if (cnt == '0) begin
                    cnt_next   = STROBE_LOAD;
                    state_next = STROBE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            STROBE: begin
                if (cnt == '0) begin
                    // Read data is sampled on the edge that ends the strobe
                    if (!req.write) begin
                        if (req.byte_mode) begin
                            rbuf_next = {8'h00, bus_data_i};
                        end else if (!byte_idx) begin
                            rbuf_next[15:8] = bus_data_i;
                        end else begin
                            rbuf_next[7:0] = bus_data_i;
                        end
                    end
                    cnt_next   = HOLD_LOAD;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            HOLD: begin
                if (cnt == '0) begin
                    if (!req.byte_mode && !byte_idx) begin
                        byte_idx_next = 1'b1;
                        cnt_next      = SETUP_LOAD;
                        state_next    = SETUP;
                    end else begin
                        rsp_valid_next = 1'b1;
                        if (!req.write) begin
                            rsp_rdata_next = rbuf;
                        end
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pin fields come straight from the latched request, so they stay put
    // through setup, strobe and hold; only byte_idx moves them between the
    // two halves of a word.
    assign req_ready_o   = (state == IDLE);
    assign bus_cs_n_o    = (state == STROBE) ? CS_ENABLED : CS_DISABLED;
    assign bus_rd_nwr_o  = req.write ? RnW_WRITE : RnW_READ;
    assign bus_bytesel_o = req.byte_mode ? req.bytesel : byte_idx;
    assign bus_reg_num_o = req.reg_num;
    assign bus_data_o    = (req.byte_mode || byte_idx) ? req.wdata[7:0] : req.wdata[15:8];
    assign bus_data_oe_o = (state != IDLE) && req.write;

    assign rsp_valid_o = rsp_valid;
    assign rsp_rdata_o = rsp_rdata;

`ifdef XOSERA_BUS_HOST_IRQ_SYNC_EN
    logic irq_n_sync;

    xosera_sync2 #(
        .RESET_VAL(1'b1)
    ) u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n_i),
        .d       (bus_irq_n_i),
        .q       (irq_n_sync)
    );

    assign irq_o = ~irq_n_sync;
`else
    assign irq_o = ~bus_irq_n_i;
`endif

endmodule

// File: tb/tb_xosera_bus_host.sv
// -----------------------------------------------------------------------------
// tb_xosera_bus_host : scoreboard bench for xosera_bus_host
//
// Requests are modelled as whole register accesses against a small register
// file; every accepted request pushes its expected byte cycles and its
// expected response into queues that two independent monitors drain.
// -----------------------------------------------------------------------------
module tb_xosera_bus_host;

    localparam int SETUP  = 2;
    localparam int STROBE = 4;
    localparam int HOLD   = 2;
    localparam int PER    = SETUP + STROBE + HOLD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready_o;
    logic        req_write;
    logic        req_byte;
    logic        req_bytesel;
    logic [3:0]  req_reg_num;
    logic [15:0] req_wdata;
    logic        rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        bus_cs_n_o;
    logic        bus_rd_nwr_o;
    logic        bus_bytesel_o;
    logic [3:0]  bus_reg_num_o;
    logic [7:0]  bus_data_o;
    logic        bus_data_oe_o;
    logic [7:0]  bus_data_i;
    logic        bus_irq_n;
    logic        irq_o;

    xosera_bus_host #(
        .SETUP_CYCLES (SETUP),
        .STROBE_CYCLES(STROBE),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk          (clk),
        .reset_n_i    (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write),
        .req_byte_i   (req_byte),
        .req_bytesel_i(req_bytesel),
        .req_reg_num_i(req_reg_num),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .bus_cs_n_o   (bus_cs_n_o),
        .bus_rd_nwr_o (bus_rd_nwr_o),
        .bus_bytesel_o(bus_bytesel_o),
        .bus_reg_num_o(bus_reg_num_o),
        .bus_data_o   (bus_data_o),
        .bus_data_oe_o(bus_data_oe_o),
        .bus_data_i   (bus_data_i),
        .bus_irq_n_i  (bus_irq_n),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    // Free-running count of rising edges, read on falling edges
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Target register file on the far side of the pins
    logic [7:0] target_mem [16][2];
    assign bus_data_i = (!bus_cs_n_o && bus_rd_nwr_o) ? target_mem[bus_reg_num_o][bus_bytesel_o] : 8'h00;
    always @(posedge clk) begin
        if (reset_n && !bus_cs_n_o && !bus_rd_nwr_o)
            target_mem[bus_reg_num_o][bus_bytesel_o] <= bus_data_o;
    end

    // Reference model state and scoreboard queues
    typedef struct {
        logic [15:0] rdata;
        int          acc;
        int          nbytes;
    } rsp_exp_t;

    typedef struct {
        logic       write;
        logic       bytesel;
        logic [3:0] reg_num;
        logic [7:0] data;
        int         start;
    } bus_exp_t;

    rsp_exp_t    rsp_q[$];
    bus_exp_t    bus_q[$];
    logic [7:0]  model_mem [16][2];
    logic [15:0] model_rdata = 16'h0000;
    int          last_acc    = 0;
    int          last_n      = 0;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Offer one request; hold_valid keeps req_valid high afterwards so the
    // next call chains back-to-back, chained checks the accept spacing.
    task automatic applyStimulus(input logic wr, input logic byt, input logic bs,
                                 input logic [3:0] rn, input logic [15:0] wd,
                                 input bit hold_valid, input bit chained);
        int       waited;
        int       acc;
        int       nbytes;
        int       njunk;
        bus_exp_t be;
        rsp_exp_t re;
        waited = 0;
        @(negedge clk);
        req_write   = wr;
        req_byte    = byt;
        req_bytesel = bs;
        req_reg_num = rn;
        req_wdata   = wd;
        req_valid   = 1'b1;
        while (!req_ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_o) begin
            checkOutput("ready_timeout", req_ready_o, 1);
            req_valid = 1'b0;
            return;
        end
        acc    = cyc + 1;
        nbytes = byt ? 1 : 2;
        if (chained) checkOutput("b2b_gap", acc - last_acc, last_n * PER + 1);
        last_acc = acc;
        last_n   = nbytes;

        for (int b = 0; b < nbytes; b++) begin
            be.write   = wr;
            be.reg_num = rn;
            be.bytesel = byt ? bs : (b == 1);
            be.data    = (byt || b == 1) ? wd[7:0] : wd[15:8];
            be.start   = acc + b * PER + SETUP;
            bus_q.push_back(be);
        end
        if (wr) begin
            if (byt) model_mem[rn][bs] = wd[7:0];
            else begin
                model_mem[rn][0] = wd[15:8];
                model_mem[rn][1] = wd[7:0];
            end
        end else begin
            model_rdata = byt ? {8'h00, model_mem[rn][bs]} : {model_mem[rn][0], model_mem[rn][1]};
        end
        re.rdata  = model_rdata;
        re.acc    = acc;
        re.nbytes = nbytes;
        rsp_q.push_back(re);

        @(posedge clk);
        #1;
        if (!hold_valid) begin
            // Keep offering unrelated requests for part of the transaction;
            // none of them may be accepted.
            njunk = $urandom_range(0, PER - 2);
            for (int j = 0; j < njunk; j++) begin
                @(negedge clk);
                req_write   = 1'($urandom);
                req_byte    = 1'($urandom);
                req_bytesel = 1'($urandom);
                req_reg_num = 4'($urandom);
                req_wdata   = 16'($urandom);
            end
            req_valid = 1'b0;
        end
    endtask

    // Response monitor
    always @(negedge clk) begin : rsp_mon
        rsp_exp_t e;
        if (reset_n && rsp_valid_o) begin
            if (rsp_q.size() == 0) begin
                checkOutput("unexpected_rsp", 1, 0);
            end else begin
                e = rsp_q.pop_front();
                checkOutput("rsp_latency", cyc - e.acc, e.nbytes * PER);
                checkOutput("rsp_rdata", rsp_rdata_o, e.rdata);
            end
        end
    end

    // Bus monitor: one record per cs_n low pulse
    int         low_cnt = 0;
    int         snap_start;
    logic       snap_bs, snap_rdnwr, snap_oe, stable_ok;
    logic [3:0] snap_reg;
    logic [7:0] snap_data;

    always @(negedge clk) begin : bus_mon
        bus_exp_t e;
        if (!reset_n) begin
            low_cnt = 0;
        end else if (!bus_cs_n_o) begin
            if (low_cnt == 0) begin
                snap_start = cyc;
                snap_bs    = bus_bytesel_o;
                snap_rdnwr = bus_rd_nwr_o;
                snap_oe    = bus_data_oe_o;
                snap_reg   = bus_reg_num_o;
                snap_data  = bus_data_o;
                stable_ok  = 1'b1;
            end else if (bus_bytesel_o !== snap_bs || bus_rd_nwr_o !== snap_rdnwr ||
                         bus_data_oe_o !== snap_oe || bus_reg_num_o !== snap_reg ||
                         (!snap_rdnwr && bus_data_o !== snap_data)) begin
                stable_ok = 1'b0;
            end
            low_cnt++;
        end else if (low_cnt != 0) begin
            if (bus_q.size() == 0) begin
                checkOutput("unexpected_strobe", 1, 0);
            end else begin
                e = bus_q.pop_front();
                checkOutput("strobe_len", low_cnt, STROBE);
                checkOutput("strobe_start", snap_start, e.start);
                checkOutput("bytesel", snap_bs, e.bytesel);
                checkOutput("reg_num", snap_reg, e.reg_num);
                checkOutput("rd_nwr", snap_rdnwr, !e.write);
                checkOutput("data_oe", snap_oe, e.write);
                if (e.write) checkOutput("wdata", snap_data, e.data);
                checkOutput("fields_stable", stable_ok, 1);
            end
            low_cnt = 0;
        end
    end

    task automatic drain();
        int waited;
        waited = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_rsp", rsp_q.size(), 0);
        checkOutput("drain_bus", bus_q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0] v;
        bit         prev_hold;
        bit         hold;

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_byte    = 1'b0;
        req_bytesel = 1'b0;
        req_reg_num = 4'h0;
        req_wdata   = 16'h0000;
        bus_irq_n   = 1'b1;
        for (int r = 0; r < 16; r++) begin
            for (int b = 0; b < 2; b++) begin
                v = 8'($urandom);
                target_mem[r][b] = v;
                model_mem[r][b]  = v;
            end
        end

        #1;
        checkOutput("rst_ready", req_ready_o, 1);
        checkOutput("rst_cs_n", bus_cs_n_o, 1);
        checkOutput("rst_rd_nwr", bus_rd_nwr_o, 1);
        checkOutput("rst_bytesel", bus_bytesel_o, 0);
        checkOutput("rst_reg_num", bus_reg_num_o, 0);
        checkOutput("rst_data", bus_data_o, 0);
        checkOutput("rst_oe", bus_data_oe_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata_o, 0);
        checkOutput("rst_irq", irq_o, 0);

        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        $display("[TB] directed word write / word read / byte read");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 16'hA55A, 0, 0);
        drain();
        target_mem[5][0] = 8'h12;
        target_mem[5][1] = 8'h34;
        model_mem[5][0]  = 8'h12;
        model_mem[5][1]  = 8'h34;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd5, 16'h0000, 0, 0);
        drain();
        checkOutput("word_read_value", rsp_rdata_o, 16'h1234);
        target_mem[9][1] = 8'hC7;
        model_mem[9][1]  = 8'hC7;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd9, 16'h0000, 0, 0);
        drain();
        checkOutput("byte_read_value", rsp_rdata_o, 16'h00C7);

        $display("[TB] back-to-back with req_valid held");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd7, 16'hBEEF, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd7, 16'h0000, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd7, 16'h0000, 0, 1);
        drain();

        $display("[TB] randomized traffic");
        prev_hold = 0;
        for (int i = 0; i < 60; i++) begin
            hold = (i != 59) && ($urandom_range(0, 2) == 0);
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          4'($urandom_range(0, 14)), 16'($urandom), hold, prev_hold);
            prev_hold = hold;
        end
        drain();

        $display("[TB] reset during third strobe clock of a write");
        @(negedge clk);
        req_write   = 1'b1;
        req_byte    = 1'b0;
        req_bytesel = 1'b0;
        req_reg_num = 4'd15;
        req_wdata   = 16'h5AA5;
        req_valid   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (SETUP + 2) @(posedge clk);
        #2;
        checkOutput("abort_in_strobe", bus_cs_n_o, 0);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_cs_n", bus_cs_n_o, 1);
        checkOutput("abort_oe", bus_data_oe_o, 0);
        checkOutput("abort_ready", req_ready_o, 1);
        checkOutput("abort_rsp_valid", rsp_valid_o, 0);
        checkOutput("abort_rdata", rsp_rdata_o, 0);
        model_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (2 * PER) @(negedge clk);
        checkOutput("post_abort_ready", req_ready_o, 1);
        checkOutput("post_abort_cs_n", bus_cs_n_o, 1);

        $display("[TB] interrupt path");
        @(negedge clk);
        bus_irq_n = 1'b0;
`ifdef XOSERA_BUS_HOST_IRQ_SYNC_EN
        #1 checkOutput("irq_sync_0", irq_o, 0);
        @(posedge clk);
        #1 checkOutput("irq_sync_1", irq_o, 0);
        @(posedge clk);
        #1 checkOutput("irq_sync_2", irq_o, 1);
        @(negedge clk);
        bus_irq_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkOutput("irq_sync_clear", irq_o, 0);
`else
        #1 checkOutput("irq_comb_set", irq_o, 1);
        @(negedge clk);
        bus_irq_n = 1'b1;
        #1 checkOutput("irq_comb_clear", irq_o, 0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
